// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter: round-robin pick in IDLE,
// grant locked for one full request/response transaction.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_WIDTH-1:0] ifu_resp_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
    input  logic [MASK_WIDTH-1:0] lsu_req_wmask,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_WIDTH-1:0] lsu_resp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [MASK_WIDTH-1:0] mem_req_wmask,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    output logic                  busy,
    output logic                  grant_lsu
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  wen;
        logic [DATA_WIDTH-1:0] wdata;
        logic [MASK_WIDTH-1:0] wmask;
    } mem_req_t;

    state_t   state_q, state_d;
    logic     owner_q, owner_d;      // 1 = LSU
    logic     last_grant_q, last_grant_d;
    logic     sel_lsu;
    logic     req_hs, resp_hs;
    mem_req_t ifu_req, lsu_req, fwd_req;

    // IFU is read-only: write fields are forced to zero on the shared port
    assign ifu_req = '{addr: ifu_req_addr, wen: 1'b0, wdata: '0, wmask: '0};
    assign lsu_req = '{addr: lsu_req_addr, wen: lsu_req_wen, wdata: lsu_req_wdata,
                       wmask: lsu_req_wmask};

    // Round-robin only in IDLE; afterwards the latched owner holds the port
    assign sel_lsu = (state_q == IDLE) ? (lsu_req_valid && (!ifu_req_valid || !last_grant_q))
                                       : owner_q;
    assign fwd_req = sel_lsu ? lsu_req : ifu_req;

    assign mem_req_addr   = fwd_req.addr;
    assign mem_req_wen    = fwd_req.wen;
    assign mem_req_wdata  = fwd_req.wdata;
    assign mem_req_wmask  = fwd_req.wmask;
    assign ifu_resp_rdata = mem_resp_rdata;
    assign lsu_resp_rdata = mem_resp_rdata;
    assign busy           = (state_q != IDLE);
    assign grant_lsu      = owner_q;

    always_comb begin
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        case (state_q)
            IDLE: mem_req_valid = ifu_req_valid || lsu_req_valid;
            REQ:  mem_req_valid = sel_lsu ? lsu_req_valid : ifu_req_valid;
            RESP: begin
                mem_resp_ready = owner_q ? lsu_resp_ready : ifu_resp_ready;
                ifu_resp_valid = !owner_q && mem_resp_valid;
                lsu_resp_valid = owner_q && mem_resp_valid;
            end
            default: ;
        endcase
        // Handshakes are suppressed while reset is held
        if (rst) begin
            mem_req_valid  = 1'b0;
            mem_resp_ready = 1'b0;
            ifu_resp_valid = 1'b0;
            lsu_resp_valid = 1'b0;
        end
    end

    assign req_hs        = mem_req_valid && mem_req_ready;
    assign resp_hs       = mem_resp_valid && mem_resp_ready;
    assign ifu_req_ready = req_hs && !sel_lsu;
    assign lsu_req_ready = req_hs && sel_lsu;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: if (mem_req_valid) begin
                owner_d = sel_lsu;
                state_d = mem_req_ready ? RESP : REQ;
            end
            REQ:  if (req_hs) state_d = RESP;
            RESP: if (resp_hs) begin
                state_d      = IDLE;
                last_grant_d = owner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;  // IFU wins the first tie
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked
// against a transaction-phase reference model.
module tb_mem_arbiter;
    localparam int AW = 32, DW = 32, MW = 4;

    logic clk = 1'b0, rst;
    logic ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [AW-1:0] ifu_req_addr;
    logic [DW-1:0] ifu_resp_rdata;
    logic lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready;
    logic [AW-1:0] lsu_req_addr;
    logic [DW-1:0] lsu_req_wdata, lsu_resp_rdata;
    logic [MW-1:0] lsu_req_wmask;
    logic mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid, mem_resp_ready;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata, mem_resp_rdata;
    logic [MW-1:0] mem_req_wmask;
    logic busy, grant_lsu;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_resp_ready(ifu_resp_ready), .ifu_resp_rdata(ifu_resp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_resp_rdata(lsu_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_rdata(mem_resp_rdata),
        .busy(busy), .grant_lsu(grant_lsu)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 = no transaction, 1 = granted but not yet
    // accepted by memory, 2 = accepted and awaiting response.
    int m_phase = 0, n_phase;
    bit m_own = 0, m_last = 1, m_gl = 0;
    bit n_own, n_last, n_gl;
    bit f_acc_i, f_acc_l, f_req_hs, f_resp_hs;

    task automatic cycle();
        bit who, e_mv, e_irv, e_lrv, e_mrr;
        #1;
        n_phase = m_phase; n_own = m_own; n_last = m_last; n_gl = m_gl;
        f_acc_i = 0; f_acc_l = 0; f_req_hs = 0; f_resp_hs = 0;
        if (rst) begin
            chk("rst_ifu_req_ready", ifu_req_ready, 0);
            chk("rst_lsu_req_ready", lsu_req_ready, 0);
            chk("rst_ifu_resp_valid", ifu_resp_valid, 0);
            chk("rst_lsu_resp_valid", lsu_resp_valid, 0);
            chk("rst_mem_req_valid", mem_req_valid, 0);
            chk("rst_mem_resp_ready", mem_resp_ready, 0);
            n_phase = 0; n_own = 0; n_last = 1; n_gl = 0;
            return;
        end
        if (m_phase == 0) begin
            if (ifu_req_valid && lsu_req_valid) who = !m_last;
            else who = lsu_req_valid;
            e_mv = ifu_req_valid || lsu_req_valid;
        end else begin
            who  = m_own;
            e_mv = (m_phase == 1) && (who ? lsu_req_valid : ifu_req_valid);
        end
        e_irv = (m_phase == 2) && !m_own && mem_resp_valid;
        e_lrv = (m_phase == 2) && m_own && mem_resp_valid;
        e_mrr = (m_phase == 2) && (m_own ? lsu_resp_ready : ifu_resp_ready);
        f_req_hs  = e_mv && mem_req_ready;
        f_acc_i   = f_req_hs && !who;
        f_acc_l   = f_req_hs && who;
        f_resp_hs = e_mrr && mem_resp_valid;

        chk("busy", busy, m_phase != 0);
        chk("grant_lsu", grant_lsu, m_gl);
        chk("mem_req_valid", mem_req_valid, e_mv);
        chk("ifu_req_ready", ifu_req_ready, f_acc_i);
        chk("lsu_req_ready", lsu_req_ready, f_acc_l);
        chk("ifu_resp_valid", ifu_resp_valid, e_irv);
        chk("lsu_resp_valid", lsu_resp_valid, e_lrv);
        chk("mem_resp_ready", mem_resp_ready, e_mrr);
        if (e_mv) begin
            chk("mem_req_addr", mem_req_addr, who ? lsu_req_addr : ifu_req_addr);
            chk("mem_req_wen", mem_req_wen, who && lsu_req_wen);
            chk("mem_req_wdata", mem_req_wdata, who ? lsu_req_wdata : '0);
            chk("mem_req_wmask", mem_req_wmask, who ? lsu_req_wmask : '0);
        end
        if (e_irv) chk("ifu_resp_rdata", ifu_resp_rdata, mem_resp_rdata);
        if (e_lrv) chk("lsu_resp_rdata", lsu_resp_rdata, mem_resp_rdata);

        if (m_phase == 0 && e_mv) begin
            n_own = who; n_gl = who; n_phase = mem_req_ready ? 2 : 1;
        end else if (m_phase == 1 && f_req_hs) begin
            n_phase = 2;
        end else if (m_phase == 2 && f_resp_hs) begin
            n_phase = 0; n_last = m_own;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_phase = n_phase; m_own = n_own; m_last = n_last; m_gl = n_gl;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0;
        ifu_req_valid = 0; ifu_req_addr = '0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0;
        lsu_req_wdata = '0; lsu_req_wmask = '0; lsu_resp_ready = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    endtask

    bit ifu_pend, lsu_pend, mem_pend, mem_rv_on;

    initial begin
        idle_inputs();
        rst = 1;
        cycle(); tick();
        rst = 0;
        cycle(); chk("reset_busy", busy, 0); chk("reset_grant_lsu", grant_lsu, 0); tick();

        // Single IFU read
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000; mem_req_ready = 1;
        cycle(); chk("t1_ifu_req_ready", ifu_req_ready, 1); chk("t1_busy0", busy, 0); tick();
        idle_inputs(); mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0413; ifu_resp_ready = 1;
        cycle();
        chk("t1_ifu_resp_valid", ifu_resp_valid, 1);
        chk("t1_rdata", ifu_resp_rdata, 32'h0000_0413);
        chk("t1_lsu_resp_valid", lsu_resp_valid, 0);
        chk("t1_busy1", busy, 1);
        tick();
        idle_inputs(); cycle(); chk("t1_busy_after", busy, 0); tick();

        // LSU write
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_0100; lsu_req_wen = 1;
        lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'b0011; mem_req_ready = 1;
        cycle();
        chk("t2_addr", mem_req_addr, 32'h8000_0100); chk("t2_wen", mem_req_wen, 1);
        chk("t2_wdata", mem_req_wdata, 32'hDEAD_BEEF); chk("t2_wmask", mem_req_wmask, 4'b0011);
        chk("t2_lsu_req_ready", lsu_req_ready, 1);
        tick();
        idle_inputs(); mem_resp_valid = 1; lsu_resp_ready = 1;
        cycle(); chk("t2_ack", lsu_resp_valid, 1); tick();
        idle_inputs(); cycle(); chk("t2_grant_lsu", grant_lsu, 1); tick();

        // Grant lock: IFU waits 3 cycles for memory, LSU arrives in cycle 1
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0040;
        for (int c = 0; c < 4; c++) begin
            mem_req_ready = (c == 3);
            if (c >= 1) begin
                lsu_req_valid = 1; lsu_req_addr = 32'h8000_0200; lsu_req_wen = 0;
            end
            cycle();
            chk("t3_addr_locked", mem_req_addr, 32'h8000_0040);
            chk("t3_lsu_req_ready", lsu_req_ready, 0);
            chk("t3_ifu_req_ready", ifu_req_ready, c == 3);
            tick();
        end
        ifu_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 1; ifu_resp_ready = 1;
        cycle(); tick();
        // Response backpressure on the LSU read that follows
        mem_resp_valid = 0; ifu_resp_ready = 0; mem_req_ready = 1;
        cycle(); chk("t3_lsu_next", lsu_req_ready, 1); tick();
        lsu_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            lsu_resp_ready = (c == 2);
            cycle();
            chk("t5_mem_resp_ready", mem_resp_ready, c == 2);
            chk("t5_busy", busy, 1);
            chk("t5_rdata", lsu_resp_rdata, 32'h1234_5678);
            tick();
        end
        idle_inputs(); cycle(); chk("t5_idle", busy, 0); tick();

        // Reset during RESP of an LSU read, then ties alternate IFU, LSU, IFU
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_0300; mem_req_ready = 1;
        cycle(); tick();
        idle_inputs(); rst = 1; mem_resp_valid = 1; lsu_resp_ready = 1;
        cycle(); chk("t6_no_resp", lsu_resp_valid, 0); tick();
        idle_inputs(); cycle(); chk("t6_busy", busy, 0); tick();
        for (int k = 0; k < 3; k++) begin
            ifu_req_valid = 1; ifu_req_addr = 32'h8000_1000;
            lsu_req_valid = 1; lsu_req_addr = 32'h8000_2000; mem_req_ready = 1;
            mem_resp_valid = 0;
            cycle();
            chk("t4_tie_ifu", ifu_req_ready, (k % 2) == 0);
            chk("t4_tie_lsu", lsu_req_ready, (k % 2) == 1);
            tick();
            mem_req_ready = 0; mem_resp_valid = 1; ifu_resp_ready = 1; lsu_resp_ready = 1;
            cycle(); tick();
        end

        // Random traffic
        idle_inputs();
        ifu_pend = 0; lsu_pend = 0; mem_pend = 0; mem_rv_on = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!ifu_pend && $urandom_range(0, 2) == 0) begin
                ifu_pend = 1; ifu_req_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsu_pend && $urandom_range(0, 2) == 0) begin
                lsu_pend = 1; lsu_req_addr = $urandom; lsu_req_wen = $urandom_range(0, 1);
                lsu_req_wdata = $urandom; lsu_req_wmask = $urandom_range(0, 15);
            end
            ifu_req_valid  = ifu_pend;
            lsu_req_valid  = lsu_pend;
            ifu_resp_ready = $urandom_range(0, 2) != 0;
            lsu_resp_ready = $urandom_range(0, 2) != 0;
            mem_req_ready  = $urandom_range(0, 2) != 0;
            if (mem_pend) begin
                if (!mem_rv_on && $urandom_range(0, 1) == 0) begin
                    mem_rv_on = 1; mem_resp_rdata = $urandom;
                end
                mem_resp_valid = mem_rv_on;
            end else begin
                mem_resp_valid = ($urandom_range(0, 15) == 0);
                mem_resp_rdata = $urandom;
            end
            cycle();
            if (rst) begin
                mem_pend = 0; mem_rv_on = 0;
            end else begin
                if (f_acc_i) ifu_pend = 0;
                if (f_acc_l) lsu_pend = 0;
                if (f_resp_hs) begin mem_pend = 0; mem_rv_on = 0; end
                if (f_req_hs) begin mem_pend = 1; mem_rv_on = 0; end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
